// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with a DEPTH x 32-bit register memory behind a BASE_ADDR window.
// Define AHB_SLAVE_WAIT_EN to insert one wait state before every in-window data phase.
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic        hreadyin,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

`ifdef AHB_SLAVE_WAIT_EN
  localparam state_e ST_FIRST = ST_WAIT;
`else
  localparam state_e ST_FIRST = ST_DATA;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic             win_q, win_d;
  logic [31:0]      mem_q [DEPTH];

  logic [31:0]      offset;
  logic             in_win;
  logic             ready;
  logic             accept;
  logic             mem_we;
  logic             unused_htrans0;

  // Wrapping subtraction makes addresses below the base look huge, so one compare covers both bounds.
  assign offset         = haddr - BASE_ADDR;
  assign in_win         = (offset < DEPTH);
  assign ready          = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign hreadyout      = ready;
  assign accept         = hreadyin & ready & htrans[1];
  assign unused_htrans0 = htrans[0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = write_q;
    win_d   = win_q;
    hresp   = 2'b00;
    hrdata  = '0;
    mem_we  = 1'b0;

    case (state_q)
      ST_WAIT: state_d = ST_DATA;
      ST_ERR1: begin
        hresp   = 2'b01;
        state_d = ST_ERR2;
      end
      ST_DATA: begin
        if (write_q) mem_we = win_q;
        else         hrdata = mem_q[idx_q];
      end
      ST_ERR2: hresp = 2'b01;
      default: ;
    endcase

    // Any ready state is also a potential address phase for the next transfer.
    if (ready) begin
      if (accept) begin
        idx_d   = offset[IDX_W-1:0];
        write_d = hwrite;
        win_d   = in_win;
        state_d = in_win ? ST_FIRST : ST_ERR1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      win_q   <= win_d;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx_q] <= hwdata;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: transaction-level memory model checked every cycle.
module tb_ahb_slave_mem;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int WAITS = 1;
`else
  localparam int WAITS = 0;
`endif

  logic        hclk, hresetn;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [1:0]  htrans;
  logic        hreadyin;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  ahb_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .hwdata(hwdata),
    .hwrite(hwrite), .htrans(htrans), .hreadyin(hreadyin),
    .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        q_wr[$];
  logic [1:0]  q_trans[$];
  logic        q_hrin[$];

  function automatic bit in_win(input logic [31:0] a);
    return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(DEPTH));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a - BASE);
  endfunction

  task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [1:0] t, input logic hr);
    q_addr.push_back(a); q_wr.push_back(w); q_data.push_back(d);
    q_trans.push_back(t); q_hrin.push_back(hr);
  endtask

  // Plays queued transfers as a pipelined AHB master; the model predicts each data phase.
  task automatic run(input string name);
    int          a_i = 0;
    int          cyc = 0;
    bit          p_v = 0;
    bit          p_wr = 0;
    int          p_cnt = 0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;
    bit          exp_rdy, done;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    while ((a_i < q_addr.size() || p_v) && cyc < 3000) begin
      if (a_i < q_addr.size()) begin
        haddr = q_addr[a_i]; hwrite = q_wr[a_i]; htrans = q_trans[a_i]; hreadyin = q_hrin[a_i];
      end else begin
        haddr = $urandom; hwrite = 1'($urandom); htrans = 2'b00; hreadyin = 1'b1;
      end
      hwdata = (p_v && p_wr) ? p_data : $urandom;

      exp_rdy = 1'b1; exp_resp = 2'b00; exp_rd = '0; done = 1'b0;
      if (p_v) begin
        if (!in_win(p_addr)) begin
          exp_resp = 2'b01;
          exp_rdy  = (p_cnt == 1);
        end else begin
          exp_rdy = (p_cnt == WAITS);
          if (exp_rdy && !p_wr) exp_rd = ref_mem[idx_of(p_addr)];
        end
        done = exp_rdy;
      end

      @(negedge hclk);
      checks += 3;
      if (hreadyout !== exp_rdy)
        $display("FAIL %s hreadyout cyc=%0d addr=%h got=%b exp=%b", name, cyc, p_addr, hreadyout, exp_rdy);
      if (hresp !== exp_resp)
        $display("FAIL %s hresp cyc=%0d addr=%h got=%b exp=%b", name, cyc, p_addr, hresp, exp_resp);
      if (hrdata !== exp_rd)
        $display("FAIL %s hrdata cyc=%0d addr=%h got=%h exp=%h", name, cyc, p_addr, hrdata, exp_rd);
      if (hreadyout !== exp_rdy) errors++;
      if (hresp !== exp_resp) errors++;
      if (hrdata !== exp_rd) errors++;

      if (done && p_wr && in_win(p_addr)) ref_mem[idx_of(p_addr)] = p_data;
      if (p_v) p_cnt++;
      if (done) p_v = 0;
      if (exp_rdy && a_i < q_addr.size()) begin
        if (htrans[1] && hreadyin) begin
          p_v = 1; p_addr = haddr; p_wr = hwrite; p_data = q_data[a_i]; p_cnt = 0;
        end
        a_i++;
      end
      @(posedge hclk); #1;
      cyc++;
    end
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL %s timeout got=%0d cycles exp=<3000", name, cyc);
    end
    q_addr.delete(); q_wr.delete(); q_data.delete(); q_trans.delete(); q_hrin.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks += 3;
    if (hreadyout !== 1'b1) begin errors++; $display("FAIL %s hreadyout got=%b exp=1", name, hreadyout); end
    if (hresp !== 2'b00)    begin errors++; $display("FAIL %s hresp got=%b exp=00", name, hresp); end
    if (hrdata !== 32'h0)   begin errors++; $display("FAIL %s hrdata got=%h exp=0", name, hrdata); end
  endtask

  task automatic test_reset();
    hresetn = 1'b0; haddr = BASE; hwdata = '0; hwrite = 1'b0; htrans = 2'b10; hreadyin = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #1 check_reset_outputs("reset_async");
    repeat (2) @(posedge hclk);
    @(negedge hclk) check_reset_outputs("reset_held");
    @(posedge hclk); #1;
    hresetn = 1'b1;
  endtask

  task automatic test_single();
    push(BASE, 1'b1, 32'h24, 2'b10, 1'b1);
    push(BASE, 1'b0, 32'h0,  2'b10, 1'b1);
    run("single");
  endtask

  task automatic test_incr4();
    logic [31:0] d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) push(BASE + 32'(i), 1'b1, d[i], (i == 0) ? 2'b10 : 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) push(BASE + 32'(i), 1'b0, 32'h0, (i == 0) ? 2'b10 : 2'b11, 1'b1);
    run("incr4");
  endtask

  task automatic test_error();
    push(32'h9000_0000, 1'b0, 32'h0, 2'b10, 1'b1);
    push(BASE + 32'(DEPTH), 1'b1, 32'hBAD0_0001, 2'b10, 1'b1);
    push(BASE - 32'd1, 1'b1, 32'hBAD0_0002, 2'b10, 1'b1);
    push(BASE + 32'(DEPTH - 1), 1'b1, 32'h0000_0EDE, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) push(BASE + 32'(i), 1'b0, 32'h0, 2'b10, 1'b1);
    push(BASE + 32'(DEPTH - 1), 1'b0, 32'h0, 2'b10, 1'b1);
    run("error");
  endtask

  task automatic test_raw();
    push(BASE + 32'd5, 1'b1, 32'hA5, 2'b10, 1'b1);
    push(BASE + 32'd5, 1'b0, 32'h0,  2'b10, 1'b1);
    run("raw");
  endtask

  task automatic test_idle_busy();
    push(BASE + 32'd7, 1'b1, 32'h7777_0000, 2'b00, 1'b1);
    push(BASE + 32'd7, 1'b1, 32'h7777_0001, 2'b01, 1'b1);
    push(BASE + 32'd7, 1'b1, 32'h7777_0002, 2'b10, 1'b0);
    push(BASE + 32'd7, 1'b0, 32'h0,         2'b10, 1'b1);
    run("idle_busy");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  t;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(9, 0))
        0:       a = BASE + 32'(DEPTH) + 32'($urandom_range(15, 0));
        1:       a = BASE - 32'd1 - 32'($urandom_range(15, 0));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(DEPTH - 1, 0));
      endcase
      t = ($urandom_range(5, 0) == 0) ? 2'($urandom) : {1'b1, 1'($urandom)};
      push(a, 1'($urandom), $urandom, t, ($urandom_range(9, 0) != 0));
    end
    for (int i = 0; i < DEPTH; i++) push(BASE + 32'(i), 1'b0, 32'h0, (i == 0) ? 2'b10 : 2'b11, 1'b1);
    run("random");
  endtask

  task automatic test_reset_mid_write();
    push(BASE + 32'd2, 1'b1, 32'h5555_2222, 2'b10, 1'b1);
    run("pre_reset_write");
    haddr = BASE + 32'd2; hwrite = 1'b1; htrans = 2'b10; hreadyin = 1'b1;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
    #2 hresetn = 1'b0;
    #1 check_reset_outputs("reset_mid_write");
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    push(BASE + 32'd2, 1'b0, 32'h0, 2'b10, 1'b1);
    push(BASE + 32'd5, 1'b0, 32'h0, 2'b10, 1'b1);
    push(BASE,         1'b0, 32'h0, 2'b10, 1'b1);
    run("post_reset_read");
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr4();
    test_error();
    test_raw();
    test_idle_busy();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
